// File: rtl/display_pkg.sv
// display_pkg: shared scan-state type, digit width and one-hot digit decode
// Contents: scan_state_t {SCAN_BLANK, SCAN_SHOW}, DIGIT_W, digit_onehot()
package display_pkg;
  typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_state_t;
  localparam int DIGIT_W = 4;
  function automatic logic [31:0] digit_onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/display_scan_ctrl_dwell_timer.sv
// dwell_timer: up-counter that flags its terminal count and restarts on load
// Ports: clk, rst (sync, active-high), load_i restarts the count at 0,
//        term_i terminal value, expire_o high while the count equals term_i
module dwell_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] term_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expire_o = cnt_q == term_i;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 7-segment scan with double-buffered digit load
// Ports: clk, reset (sync, active-high); load_valid/load_data/load_ready producer
//        handshake; digit_en one-hot digit enable; nibble current digit value;
//        frame_done pulse in the last lit cycle of each frame.
// Option: define SCAN_BLANK_EN to insert BLANK_CYCLES dark cycles between digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NDIG         = 2,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic [DIGIT_W*NDIG-1:0] load_data,
  output logic                    load_ready,
  output logic [NDIG-1:0]         digit_en,
  output logic [DIGIT_W-1:0]      nibble,
  output logic                    frame_done
);
  localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int IW = $clog2(NDIG);
`ifdef SCAN_BLANK_EN
  localparam int BLANK_T  = BLANK_CYCLES - 1;
  localparam bit BLANK_EN = 1'b1;
`else
  localparam int BLANK_T  = 0;
  localparam bit BLANK_EN = 1'b0;
`endif
  scan_state_t             state_q;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGIT_W*NDIG-1:0] active_q, pend_q;
  logic                    pend_v_q, expire, adv, commit, xfer;
  logic [CW-1:0]           term;
  always_comb begin
    term   = state_q == SCAN_SHOW ? CW'(DWELL_CYCLES - 1) : CW'(BLANK_T);
    idx_d  = idx_q == IW'(NDIG - 1) ? '0 : idx_q + 1'b1;
    adv    = expire && (state_q == SCAN_BLANK || !BLANK_EN);
    commit = adv && idx_d == '0 && pend_v_q;
    xfer   = load_valid && load_ready;
  end
  // every state change happens on expire, so expire doubles as the reload
  dwell_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load_i   (expire),
    .term_i   (term),
    .expire_o (expire)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q  <= SCAN_BLANK;
      idx_q    <= IW'(NDIG - 1);
      active_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      if (expire) state_q <= adv ? SCAN_SHOW : SCAN_BLANK;
      if (adv) idx_q <= idx_d;
      if (commit) active_q <= pend_q;
      if (xfer) pend_q <= load_data;
      pend_v_q <= xfer || (pend_v_q && !commit);
    end
  assign load_ready = ~pend_v_q;
  assign digit_en   = state_q == SCAN_SHOW ? NDIG'(digit_onehot(32'(idx_q))) : '0;
  assign nibble     = active_q[DIGIT_W*idx_q +: DIGIT_W];
  assign frame_done = state_q == SCAN_SHOW && idx_q == IW'(NDIG - 1) && expire;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized self-checking bench against a timeline model
module tb_display_scan_ctrl;
  localparam int N = 2;
  localparam int D = 4;
  localparam int B = 2;
  localparam int P = D + B;
`ifdef SCAN_BLANK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif
  localparam int FR = BL ? N * P : N * D;
  logic clk = 0, reset = 1, load_valid = 0, load_ready, frame_done;
  logic [4*N-1:0] load_data = '0;
  logic [N-1:0] digit_en;
  logic [3:0] nibble;
  display_scan_ctrl #(.NDIG(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .digit_en(digit_en), .nibble(nibble), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, t = 0;
  logic [4*N-1:0] m_act, m_pend;
  bit m_pv, last_acc;
  logic [N-1:0] e_en;
  logic [3:0] e_nib;
  logic e_rdy, e_fd;
  // timeline since reset release: t = cycle index of the first post-reset cycle = 0
  function automatic bit show_at(int tt);
    if (BL) return (tt % P) >= B;
    return tt != 0;
  endfunction
  function automatic int idx_at(int tt);
    if (BL) return (tt % P) >= B ? (tt / P) % N : (tt / P + N - 1) % N;
    return tt == 0 ? N - 1 : ((tt - 1) / D) % N;
  endfunction
  function automatic bit fstart_at(int tt);
    if (!show_at(tt) || idx_at(tt) != 0) return 0;
    return BL ? (tt % P) == B : ((tt - 1) % D) == 0;
  endfunction
  function automatic bit fd_at(int tt);
    if (!show_at(tt) || idx_at(tt) != N - 1) return 0;
    return BL ? (tt % P) == P - 1 : ((tt - 1) % D) == D - 1;
  endfunction
  task automatic expect_now();
    int i;
    i = idx_at(t);
    e_en  = show_at(t) ? N'(1 << i) : '0;
    e_nib = m_act[4*i +: 4];
    e_rdy = !m_pv;
    e_fd  = fd_at(t);
  endtask
  task automatic tick();
    bit commit;
    commit = fstart_at(t + 1) && m_pv;
    last_acc = load_valid && !m_pv;
    if (last_acc) begin m_pend = load_data; m_pv = 1; end
    if (commit) begin m_act = m_pend; m_pv = 0; end
    @(posedge clk); #1; t++;
  endtask
  task automatic do_reset();
    reset = 1; load_valid = 0;
    @(posedge clk); #1;
    reset = 0; t = 0; m_act = '0; m_pend = '0; m_pv = 0; last_acc = 0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp += 4;
    if (digit_en !== '0) begin n_bad++; $display("FAIL reset digit_en got %b exp 0", digit_en); end
    if (nibble !== 4'h0) begin n_bad++; $display("FAIL reset nibble got %h exp 0", nibble); end
    if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reset load_ready got %b exp 1", load_ready); end
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset frame_done got %b exp 0", frame_done); end
  endtask
  task automatic test_scan();
    int n_fd, exp_fd, prev;
    n_fd = 0; exp_fd = 0; prev = -1;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      expect_now();
      n_cmp += 4;
      if (digit_en !== e_en) begin n_bad++; $display("FAIL scan digit_en t=%0d got %b exp %b", t, digit_en, e_en); end
      if (nibble !== e_nib) begin n_bad++; $display("FAIL scan nibble t=%0d got %h exp %h", t, nibble, e_nib); end
      if (load_ready !== e_rdy) begin n_bad++; $display("FAIL scan load_ready t=%0d got %b exp %b", t, load_ready, e_rdy); end
      if (frame_done !== e_fd) begin n_bad++; $display("FAIL scan frame_done t=%0d got %b exp %b", t, frame_done, e_fd); end
      if (e_fd) exp_fd++;
      if (frame_done === 1'b1) begin
        n_fd++;
        if (prev >= 0) begin
          n_cmp++;
          if (t - prev !== FR) begin n_bad++; $display("FAIL frame_period got %0d exp %0d", t - prev, FR); end
        end
        prev = t;
      end
      tick();
    end
    n_cmp++;
    if (n_fd !== exp_fd) begin n_bad++; $display("FAIL frame_count got %0d exp %0d", n_fd, exp_fd); end
  endtask
  task automatic test_load();
    do_reset();
    for (int c = 0; c < 36; c++) begin
      if (c == 3) begin load_valid = 1; load_data = 8'h3A; end
      expect_now();
      n_cmp += 4;
      if (digit_en !== e_en) begin n_bad++; $display("FAIL load digit_en t=%0d got %b exp %b", t, digit_en, e_en); end
      if (nibble !== e_nib) begin n_bad++; $display("FAIL load nibble t=%0d got %h exp %h", t, nibble, e_nib); end
      if (load_ready !== e_rdy) begin n_bad++; $display("FAIL load load_ready t=%0d got %b exp %b", t, load_ready, e_rdy); end
      if (frame_done !== e_fd) begin n_bad++; $display("FAIL load frame_done t=%0d got %b exp %b", t, frame_done, e_fd); end
      tick();
      if (last_acc) load_valid = 0;
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    load_valid = 1; load_data = 8'h3A;
    for (int c = 0; c < 48; c++) begin
      expect_now();
      n_cmp += 4;
      if (digit_en !== e_en) begin n_bad++; $display("FAIL b2b digit_en t=%0d got %b exp %b", t, digit_en, e_en); end
      if (nibble !== e_nib) begin n_bad++; $display("FAIL b2b nibble t=%0d got %h exp %h", t, nibble, e_nib); end
      if (load_ready !== e_rdy) begin n_bad++; $display("FAIL b2b load_ready t=%0d got %b exp %b", t, load_ready, e_rdy); end
      if (frame_done !== e_fd) begin n_bad++; $display("FAIL b2b frame_done t=%0d got %b exp %b", t, frame_done, e_fd); end
      tick();
      if (last_acc) begin
        if (load_data == 8'h3A) load_data = 8'h5C;
        else load_valid = 0;
      end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c == 3) begin load_valid = 1; load_data = 8'h3A; end
      tick();
      if (last_acc) load_valid = 0;
    end
    do_reset();
    for (int c = 0; c < 20; c++) begin
      expect_now();
      n_cmp += 4;
      if (digit_en !== e_en) begin n_bad++; $display("FAIL rstmid digit_en t=%0d got %b exp %b", t, digit_en, e_en); end
      if (nibble !== e_nib) begin n_bad++; $display("FAIL rstmid nibble t=%0d got %h exp %h", t, nibble, e_nib); end
      if (load_ready !== e_rdy) begin n_bad++; $display("FAIL rstmid load_ready t=%0d got %b exp %b", t, load_ready, e_rdy); end
      if (frame_done !== e_fd) begin n_bad++; $display("FAIL rstmid frame_done t=%0d got %b exp %b", t, frame_done, e_fd); end
      tick();
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!load_valid || last_acc) begin
        load_valid = $urandom_range(0, 3) == 0;
        load_data = 8'($urandom);
      end
      expect_now();
      n_cmp += 4;
      if (digit_en !== e_en) begin n_bad++; $display("FAIL rand digit_en t=%0d got %b exp %b", t, digit_en, e_en); end
      if (nibble !== e_nib) begin n_bad++; $display("FAIL rand nibble t=%0d got %h exp %h", t, nibble, e_nib); end
      if (load_ready !== e_rdy) begin n_bad++; $display("FAIL rand load_ready t=%0d got %b exp %b", t, load_ready, e_rdy); end
      if (frame_done !== e_fd) begin n_bad++; $display("FAIL rand frame_done t=%0d got %b exp %b", t, frame_done, e_fd); end
      tick();
    end
    load_valid = 0;
  endtask
  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for the multi-digit 7-segment display. It holds a double-buffered digit register and walks one-hot digit enables across `NDIG` common-anode digits with a programmable dwell time. An optional blanking interval between digits suppresses ghosting. It sits between the value producers (adder, switch logic) and the shared `sevensegment` decoder, and presents the selected nibble to that decoder.

## Interface
Parameters:
- `NDIG`, 2, number of digits scanned; must be ≥ 2.
- `DWELL_CYCLES`, 50000, clk cycles each digit is lit; must be ≥ 1.
- `BLANK_CYCLES`, 1000, clk cycles all digits are dark between digits; must be ≥ 1; used only with `SCAN_BLANK_EN`.

Ports:
- `clk`, input, 1, system clock (24 MHz HSOSC domain).
- `reset`, input, 1, synchronous, active-high.
- `load_valid`, input, 1, producer offers new digit values.
- `load_data`, input, 4*NDIG, digit values; digit k is `load_data[4k+3:4k]`.
- `load_ready`, input-side handshake output, 1, pending buffer empty.
- `digit_en`, output, NDIG, one-hot active-high digit enable; board-level inversion is outside this block.
- `nibble`, output, 4, value of the current digit, to the `sevensegment` decoder.
- `frame_done`, output, 1, single-cycle pulse at the end of each full scan.

## Operation
- Registered state: `state` ∈ {BLANK, SHOW}, `idx` (0..NDIG-1), dwell counter `cnt`, `active` buffer, `pending` buffer, and the `pend_v` flag.
- Reset values:
  - state = BLANK, idx = NDIG-1, cnt = 0.
  - active = 0, pending = 0, pend_v = 0.
  - Resulting outputs: digit_en = 0, nibble = active[idx] = 0, load_ready = 1, frame_done = 0.
- Outputs are combinational decodes of registered state:
  - digit_en = onehot(idx) in SHOW, 0 in BLANK.
  - nibble = active[4*idx +: 4] in both states.
  - load_ready = ~pend_v.
- SHOW transition: when cnt == DWELL_CYCLES-1, cnt ← 0. With the macro, go to BLANK. Without it, go to SHOW with idx+1.
- BLANK transition: when cnt == BLANK_CYCLES-1 (or after 1 cycle without the macro), cnt ← 0, state ← SHOW, idx ← idx+1.
- idx wraps from NDIG-1 to 0.
- Frame boundary is the edge where idx moves to 0 and state becomes SHOW.
  - If pend_v = 1 at that edge: active ← pending, pend_v ← 0.
- Load handshake: a transfer occurs on any edge with load_valid && load_ready. That edge sets pending ← load_data and pend_v ← 1.
  - A transfer never commits in the same edge. It is shown starting at the next frame boundary.
  - A commit and a transfer cannot coincide, because load_ready = 0 whenever pend_v = 1.
  - While load_ready = 0, the producer must hold load_valid and load_data stable.
- frame_done = 1 exactly in the final SHOW cycle of idx NDIG-1 (SHOW, idx = NDIG-1, cnt = DWELL_CYCLES-1).
- Reset mid-operation discards both buffers and restarts at BLANK, including during a pending handshake.

## Timing
- With macro:
  - digit period = DWELL_CYCLES + BLANK_CYCLES.
  - frame = NDIG × (DWELL_CYCLES + BLANK_CYCLES).
  - First lit cycle is BLANK_CYCLES cycles after reset deasserts.
- Without macro:
  - digit period = DWELL_CYCLES; frame = NDIG × DWELL_CYCLES.
  - A single BLANK cycle occurs only after reset.
- Load-to-display latency is between 1 cycle + remaining frame and 1 full frame + 1 cycle.
- load_ready reasserts the cycle after the commit edge.
- Counter width is $clog2 of the larger of DWELL_CYCLES and BLANK_CYCLES. The counter never exceeds its terminal value.

## Configuration
- `SCAN_BLANK_EN` defined: BLANK state inserted after every SHOW for BLANK_CYCLES cycles, with digit_en = 0.
- Undefined:
  - SHOW advances directly to the next digit's SHOW.
  - BLANK is reachable only from reset and lasts 1 cycle.
  - BLANK_CYCLES is ignored.

## Structure
- Package `display_pkg`:
  - `scan_state_t` enum {SCAN_BLANK, SCAN_SHOW}.
  - `DIGIT_W` = 4.
  - One-hot decode function `digit_onehot`.
  - Shared with `sevensegment` and the top level.
- Sub-module `dwell_timer`:
  - Inputs: load, terminal value.
  - Outputs: `expire` flag, asserted on the terminal count.
  - One instance, reloaded on each state change.

## Test plan
Parameters for all scenarios: NDIG = 2, DWELL_CYCLES = 4, BLANK_CYCLES = 2, macro on unless stated.
- Release reset → digit_en sequence 00×2, 01×4, 00×2, 10×4, 00×2, 01…; nibble = 0 throughout.
- Load 0x3A while idle → load_ready drops the next cycle; nibble stays 0 until the next idx-0 SHOW. Then digit 0 shows A and digit 1 shows 3; load_ready returns to 1 the cycle after that commit.
- Offer 0x3A then hold 0x5C valid → 0x5C stalls (load_ready = 0) until the 0x3A commit, is accepted the cycle after, and is displayed one frame later.
- Assert reset for 1 cycle during idx-1 SHOW with pend_v = 1 → next cycle digit_en = 00, load_ready = 1, nibble = 0, and the sequence restarts as in scenario 1.
- Run 48 cycles after reset → frame_done pulses exactly 4 times, 12 cycles apart, each coinciding with the last digit_en = 10 cycle.
- Macro off → after the 1-cycle reset blank, digit_en alternates 01×4 and 10×4 with no 00 gap; frame_done period is 8.
